pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with RUN/HALTED control and a circular return-address stack.
// Redirects take effect on the edge after the request; RAS overflow and underflow set a sticky error flag.
module pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iHalt,
  input  logic             iResume,
  input  logic             iStall,
  input  logic             iBranch,
  input  logic             iCall,
  input  logic             iRet,
  input  logic [WIDTH-1:0] iTarget,
  output logic [WIDTH-1:0] oPC,
  output logic             oValid,
  output logic             oHalted,
  output logic             oRasEmpty,
  output logic             oRasFull,
  output logic             oRasErr
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [WIDTH-1:0] RST_PC = RESET_VECTOR[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
  localparam logic [CW-1:0]    FULL_C = CW'(RAS_DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             halted_q, halted_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             push_en;

  assign pc_inc  = pc_q + INC_W;
  assign ras_top = ras_q[ptr_q - PW'(1)];

  // Next-state logic: halt beats everything in RUN, then stall > ret > call > branch > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (state_q)
      RUN: begin
        if (iHalt) begin
          state_d = HALTED;
        end else if (iStall) begin
          pc_d = pc_q;
        end else if (iRet) begin
          if (cnt_q != {CW{1'b0}}) begin
            pc_d  = ras_top;
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end else if (iCall) begin
          // When full, ptr_q already addresses the oldest entry, so the push overwrites it.
          pc_d    = iTarget;
          push_en = 1'b1;
          ptr_d   = ptr_q + PW'(1);
          if (cnt_q == FULL_C) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (iBranch) begin
          pc_d = iTarget;
        end else begin
          pc_d = pc_inc;
        end
      end
      HALTED: begin
        if (iResume && !iHalt) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign halted_d = (state_d == HALTED);
  assign empty_d  = (cnt_d == {CW{1'b0}});
  assign full_d   = (cnt_d == FULL_C);

  // Control state and status flags, with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q  <= RUN;
      pc_q     <= RST_PC;
      ptr_q    <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge iClk) begin
    if (iRst_n && push_en) begin
      ras_q[ptr_q] <= pc_inc;
    end else begin
      ras_q[ptr_q] <= ras_q[ptr_q];
    end
  end

  assign oPC       = pc_q;
  assign oValid    = (state_q == RUN) & ~iStall & ~iHalt;
  assign oHalted   = halted_q;
  assign oRasEmpty = empty_q;
  assign oRasFull  = full_q;
  assign oRasErr   = err_q;

endmodule
